// File: rtl/game_pkg.sv
// Shared types and default constants for the goose game controller and renderer.
package game_pkg;

  // Top-level game state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  // Goose jump phase
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_phase_t;

  // Gameplay defaults
  localparam logic [6:0] DEF_JUMP_PEAK       = 7'd80;
  localparam logic [6:0] DEF_JUMP_STEP       = 7'd4;
  localparam logic [9:0] DEF_OBSTACLE_WRAP   = 10'd730;
  localparam logic [3:0] DEF_SPEED_INIT      = 4'd4;
  localparam logic [3:0] DEF_SPEED_MAX       = 4'd12;
  localparam logic [3:0] DEF_SPEED_UP_EVERY  = 4'd8;
  localparam logic [5:0] DEF_RESTART_HOLDOFF = 6'd30;

  // Geometry shared with the rendering datapath
  localparam logic [9:0] FLOOR_Y    = 10'd400;
  localparam logic [6:0] GOOSE_H    = 7'd32;
  localparam logic [6:0] OBSTACLE_H = 7'd40;

  // Saturating 8-bit increment used for the score
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_controller_jump_physics.sv
// Goose jump physics: phase FSM, pending-jump request and height, stepped once per frame.
module jump_physics
  import game_pkg::*;
#(
  parameter logic [6:0] JUMP_PEAK = DEF_JUMP_PEAK,
  parameter logic [6:0] JUMP_STEP = DEF_JUMP_STEP
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        step_en,
  input  logic        btn_edge,
  input  logic        clear,
  output logic [6:0]  jump_pos,
  output jump_phase_t phase
);

  jump_phase_t phase_nx;
  logic [6:0]  pos_nx;
  logic        jump_req;
  logic        req_nx;
  logic        consume;

  // Next phase/height; a request is only consumed by a step taken from GROUND
  always_comb begin
    phase_nx = phase;
    pos_nx   = jump_pos;
    consume  = 1'b0;
    if (step_en) begin
      case (phase)
        GROUND: begin
          if (jump_req) begin
            phase_nx = RISE;
            pos_nx   = JUMP_STEP;
            consume  = 1'b1;
          end else begin
            pos_nx = 7'd0;
          end
        end
        RISE: begin
          if (jump_pos >= JUMP_PEAK - JUMP_STEP) begin
            pos_nx   = JUMP_PEAK;
            phase_nx = FALL;
          end else begin
            pos_nx = jump_pos + JUMP_STEP;
          end
        end
        FALL: begin
          if (jump_pos <= JUMP_STEP) begin
            pos_nx   = 7'd0;
            phase_nx = GROUND;
          end else begin
            pos_nx = jump_pos - JUMP_STEP;
          end
        end
        default: begin
          phase_nx = GROUND;
          pos_nx   = 7'd0;
        end
      endcase
    end else begin
      phase_nx = phase;
    end
    // A new edge wins over consumption so an edge on a step is kept for the next one
    req_nx = btn_edge | (jump_req & ~consume);
  end

  // Physics state register, cleared by reset or by a game restart
  always_ff @(posedge clk) begin
    if (sys_rst || clear) begin
      phase    <= GROUND;
      jump_pos <= 7'd0;
      jump_req <= 1'b0;
    end else begin
      phase    <= phase_nx;
      jump_pos <= pos_nx;
      jump_req <= req_nx;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Per-frame goose game sequencer: state machine, obstacle scroll, speed ramp and score.
module game_controller
  import game_pkg::*;
#(
  parameter logic [6:0] JUMP_PEAK       = DEF_JUMP_PEAK,
  parameter logic [6:0] JUMP_STEP       = DEF_JUMP_STEP,
  parameter logic [9:0] OBSTACLE_WRAP   = DEF_OBSTACLE_WRAP,
  parameter logic [3:0] SPEED_INIT      = DEF_SPEED_INIT,
  parameter logic [3:0] SPEED_MAX       = DEF_SPEED_MAX,
  parameter logic [3:0] SPEED_UP_EVERY  = DEF_SPEED_UP_EVERY,
  parameter logic [5:0] RESTART_HOLDOFF = DEF_RESTART_HOLDOFF
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       frame_tick,
  input  logic       jump_btn,
  input  logic       collision,
  output logic       game_over,
  output logic [9:0] obstacle_pos,
  output logic [6:0] jump_pos,
  output logic [7:0] score
);

  game_state_t state, state_nx;
  jump_phase_t phase;
  logic        btn_prev, btn_edge, hit;
  logic        in_run, step_en, restart, wrap;
  logic [5:0]  holdoff;
  logic [3:0]  speed, pass_cnt;
  logic [10:0] sum;
  logic [6:0]  height;

  // Decode edges, frame events and the next top-level state
  always_comb begin
    btn_edge = jump_btn & ~btn_prev;
    in_run   = (state == RUN);
    step_en  = in_run & frame_tick & ~(hit | collision);
    restart  = (state == DEAD) & btn_edge & (holdoff == RESTART_HOLDOFF);
    sum      = {1'b0, obstacle_pos} + {7'd0, speed};
    wrap     = (sum >= {1'b0, OBSTACLE_WRAP});
    state_nx = state;
    case (state)
      IDLE: begin
        if (btn_edge) state_nx = RUN;
        else          state_nx = IDLE;
      end
      RUN: begin
        if (frame_tick && (hit || collision)) state_nx = DEAD;
        else                                  state_nx = RUN;
      end
      DEAD: begin
        if (restart) state_nx = RUN;
        else         state_nx = DEAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, button history and the game-over flag
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      btn_prev  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      btn_prev  <= jump_btn;
      game_over <= (state_nx == DEAD);
    end
  end

  // Collision latch for the current frame; collision only matters while running
  always_ff @(posedge clk) begin
    if (sys_rst || restart || frame_tick) begin
      hit <= 1'b0;
    end else if (in_run && collision) begin
      hit <= 1'b1;
    end else begin
      hit <= hit;
    end
  end

  // Restart holdoff, counted in frames spent dead
  always_ff @(posedge clk) begin
    if (sys_rst || restart) begin
      holdoff <= 6'd0;
    end else if (state == DEAD && frame_tick && holdoff < RESTART_HOLDOFF) begin
      holdoff <= holdoff + 6'd1;
    end else begin
      holdoff <= holdoff;
    end
  end

  // Obstacle scroll, score and speed ramp, advanced once per surviving frame
  always_ff @(posedge clk) begin
    if (sys_rst || restart) begin
      obstacle_pos <= 10'd0;
      score        <= 8'd0;
      speed        <= SPEED_INIT;
      pass_cnt     <= 4'd0;
    end else if (step_en) begin
      if (wrap) begin
        obstacle_pos <= 10'd0;
        score        <= sat_inc8(score);
        if (pass_cnt + 4'd1 == SPEED_UP_EVERY) begin
          pass_cnt <= 4'd0;
          speed    <= (speed < SPEED_MAX) ? speed + 4'd1 : speed;
        end else begin
          pass_cnt <= pass_cnt + 4'd1;
        end
      end else begin
        obstacle_pos <= sum[9:0];
      end
    end else begin
      obstacle_pos <= obstacle_pos;
    end
  end

  jump_physics #(
    .JUMP_PEAK (JUMP_PEAK),
    .JUMP_STEP (JUMP_STEP)
  ) u_jump (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .step_en  (step_en),
    .btn_edge (btn_edge & in_run),
    .clear    (restart),
    .jump_pos (height),
    .phase    (phase)
  );

  // The goose is drawn on the floor whenever the physics core reports GROUND
  always_comb begin
    if (phase == GROUND) jump_pos = 7'd0;
    else                 jump_pos = height;
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller: table of frame sequences plus corner cases.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       jump_btn = 1'b0;
  logic       collision = 1'b0;
  logic       game_over;
  logic [9:0] obstacle_pos;
  logic [6:0] jump_pos;
  logic [7:0] score;

  int total = 0;
  int passed = 0;

  game_controller dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .frame_tick   (frame_tick),
    .jump_btn     (jump_btn),
    .collision    (collision),
    .game_over    (game_over),
    .obstacle_pos (obstacle_pos),
    .jump_pos     (jump_pos),
    .score        (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic btn;       // press the button once before the ticks
    int   ticks;     // frame ticks to apply
    int   exp_obs;
    int   exp_jump;
    int   exp_over;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    @(posedge clk); #1 jump_btn = 1'b1;
    @(posedge clk); #1 jump_btn = 0;
  endtask

  // Tick until the obstacle wraps back to 0 (one pass); a missing wrap is a failure
  task automatic run_pass();
    int n;
    tick();
    n = 1;
    while (obstacle_pos != 10'd0 && n < 400) begin
      tick();
      n++;
    end
    if (obstacle_pos != 10'd0) chk("pass_timeout", n, 0);
  endtask

  task automatic run_passes(input int n);
    for (int i = 0; i < n; i++) run_pass();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    //            btn   ticks obs  jump over
    tbl[0]  = '{1'b0,  3,    0,   0,   0};  // idle ignores frame ticks
    tbl[1]  = '{1'b1,  0,    0,   0,   0};  // start edge
    tbl[2]  = '{1'b0,  5,   20,   0,   0};  // 5 frames at speed 4
    tbl[3]  = '{1'b1,  1,   24,   4,   0};  // jump launches
    tbl[4]  = '{1'b0,  4,   40,  20,   0};
    tbl[5]  = '{1'b1, 15,  100,  80,   0};  // mid-air edge, reaches peak
    tbl[6]  = '{1'b0,  1,  104,  76,   0};
    tbl[7]  = '{1'b0, 19,  180,   0,   0};  // landed
    tbl[8]  = '{1'b0,  1,  184,   4,   0};  // pending request launches now
    tbl[9]  = '{1'b0, 39,  340,   0,   0};
    tbl[10] = '{1'b0,  1,  344,   0,   0};  // no further request

    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
    chk("reset_game_over", game_over, 0);
    chk("reset_obstacle", obstacle_pos, 0);
    chk("reset_jump", jump_pos, 0);
    chk("reset_score", score, 0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].btn) press();
      ticks(tbl[i].ticks);
      chk($sformatf("row%0d_obstacle", i), obstacle_pos, tbl[i].exp_obs);
      chk($sformatf("row%0d_jump", i), jump_pos, tbl[i].exp_jump);
      chk($sformatf("row%0d_game_over", i), game_over, tbl[i].exp_over);
    end

    // Full jump profile: 4..80 then 76..0
    press();
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("jump_t%0d", k), jump_pos, (k <= 20) ? 4 * k : 160 - 4 * k);
    end
    chk("after_jump_obstacle", obstacle_pos, 504);

    // Wrap boundary: 728 + 4 >= 730
    ticks(56);
    chk("pre_wrap_obstacle", obstacle_pos, 728);
    chk("pre_wrap_score", score, 0);
    tick();
    chk("wrap_obstacle", obstacle_pos, 0);
    chk("wrap_score", score, 1);

    // Mid-frame collision pulse
    tick();
    @(posedge clk); #1 collision = 1'b1;
    @(posedge clk); #1 collision = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("hit_pending_game_over", game_over, 0);
    tick();
    chk("dead_game_over", game_over, 1);
    chk("dead_obstacle_frozen", obstacle_pos, 4);
    ticks(2);
    chk("dead_still_frozen", obstacle_pos, 4);

    // Holdoff: edges at 10 and 29 dead frames ignored, at 30 honoured
    ticks(8);
    press();
    chk("holdoff10_ignored", game_over, 1);
    ticks(19);
    press();
    chk("holdoff29_ignored", game_over, 1);
    tick();
    press();
    chk("restart_game_over", game_over, 0);
    chk("restart_score", score, 0);
    chk("restart_obstacle", obstacle_pos, 0);
    tick();
    chk("restart_speed", obstacle_pos, 4);

    // Collision coinciding with frame_tick
    @(posedge clk); #1 frame_tick = 1'b1; collision = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0; collision = 1'b0;
    chk("same_cycle_dead", game_over, 1);
    chk("same_cycle_frozen", obstacle_pos, 4);
    ticks(30);
    press();
    chk("restart2_game_over", game_over, 0);
    chk("restart2_obstacle", obstacle_pos, 0);

    // Speed ramp and score saturation
    run_passes(8);
    chk("score8", score, 8);
    tick();
    chk("speed5", obstacle_pos, 5);
    run_passes(56);
    chk("score64", score, 64);
    tick();
    chk("speed12", obstacle_pos, 12);
    run_passes(8);
    tick();
    chk("speed_saturated", obstacle_pos, 12);
    run_passes(183);
    chk("score255", score, 255);
    run_pass();
    chk("score_saturated", score, 255);

    // Held button gives exactly one jump
    @(posedge clk); #1 jump_btn = 1'b1;
    tick();
    chk("held_launch", jump_pos, 4);
    ticks(40);
    chk("held_no_relaunch", jump_pos, 0);
    @(posedge clk); #1 jump_btn = 1'b0;

    // Reset mid-jump
    press();
    ticks(3);
    chk("pre_reset_jump", jump_pos, 12);
    @(posedge clk); #1 sys_rst = 1'b1;
    @(posedge clk); #1 sys_rst = 1'b0;
    chk("mid_reset_jump", jump_pos, 0);
    chk("mid_reset_obstacle", obstacle_pos, 0);
    chk("mid_reset_score", score, 0);
    chk("mid_reset_game_over", game_over, 0);

    // Idle ignores ticks and collision; start edge is not a jump
    @(posedge clk); #1 collision = 1'b1;
    @(posedge clk); #1 collision = 1'b0;
    tick();
    chk("idle_tick_ignored", obstacle_pos, 0);
    press();
    tick();
    chk("start_obstacle", obstacle_pos, 4);
    chk("start_no_jump", jump_pos, 0);
    chk("start_alive", game_over, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
